pwm_multi_to_value: RTL

//  Multi-channel successor to the single-channel PWM-to-value converter. Takes N receiver

---
 rtl/pwm_multi_to_value.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pwm_multi_to_value.sv
// pwm_multi_to_value: maps N receiver pulse widths (us) linearly onto
// 0..2^VALUE_WIDTH-1. Out-of-range widths are clamped. Each channel has
// loss-of-signal detection that forces a failsafe value. One round-robin
// clamp/multiply/write pipeline is shared by all channels.
module pwm_multi_to_value #(
  parameter int NUM_CH         = 4,
  parameter int TIME_WIDTH     = 16,
  parameter int VALUE_WIDTH    = 8,
  parameter int MIN_US         = 1000,
  parameter int MAX_US         = 2000,
  parameter int TIMEOUT_US     = 25000,
  parameter int FAILSAFE_VALUE = 0
) (
  input  logic                          us_clk,
  input  logic                          resetn,
  input  logic [NUM_CH*TIME_WIDTH-1:0]  pwm_time_high_us,
  input  logic [NUM_CH-1:0]             pwm_valid,
  output logic [NUM_CH*VALUE_WIDTH-1:0] value_out,
  output logic [NUM_CH-1:0]             value_updated,
  output logic [NUM_CH-1:0]             stale
);

  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_US + 1);
  localparam int PROD_W = TIME_WIDTH + VALUE_WIDTH + 16;

  // Fixed-point gain (16 fractional bits) from microseconds above MIN_US to output counts.
  localparam logic [PROD_W-1:0] SCALE =
    PROD_W'((((64'd1 << VALUE_WIDTH) - 64'd1) << 16) / 64'(MAX_US - MIN_US));
  localparam logic [TIME_WIDTH-1:0]  MIN_T    = TIME_WIDTH'(MIN_US);
  localparam logic [TIME_WIDTH-1:0]  MAX_T    = TIME_WIDTH'(MAX_US);
  localparam logic [CNT_W-1:0]       CNT_MAX  = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0]       CNT_FIRE = CNT_W'(TIMEOUT_US - 1);
  localparam logic [VALUE_WIDTH-1:0] FAILSAFE = VALUE_WIDTH'(FAILSAFE_VALUE);
  localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(NUM_CH - 1);

  logic [TIME_WIDTH-1:0]  w_time    [NUM_CH];
  logic [VALUE_WIDTH-1:0] r_value   [NUM_CH];
  logic [CNT_W-1:0]       r_cnt     [NUM_CH];
  logic [NUM_CH-1:0]      r_pending;
  logic [NUM_CH-1:0]      w_pending_nxt;
  logic [NUM_CH-1:0]      w_timeout;
  logic [PTR_W-1:0]       r_ptr;
  logic                   w_capture;

  // Pipeline registers; each stage carries its channel index.
  logic                   r_s1_vld;
  logic [PTR_W-1:0]       r_s1_ch;
  logic [TIME_WIDTH-1:0]  r_s1_t;
  logic                   r_s2_vld;
  logic [PTR_W-1:0]       r_s2_ch;
  logic [TIME_WIDTH-1:0]  r_s2_d;
  logic                   r_s2_sat;
  logic                   r_s3_vld;
  logic [PTR_W-1:0]       r_s3_ch;
  logic [PROD_W-1:0]      r_s3_p;
  logic                   r_s3_sat;

  logic [TIME_WIDTH-1:0]  w_s1_d;
  logic                   w_s1_sat;
  logic [PROD_W-1:0]      w_s2_p;
  logic [VALUE_WIDTH-1:0] w_s3_v;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_time[g]                                 = pwm_time_high_us[g*TIME_WIDTH +: TIME_WIDTH];
    assign value_out[g*VALUE_WIDTH +: VALUE_WIDTH]   = r_value[g];
    // Fires only on the step into saturation; a same-cycle strobe suppresses it.
    assign w_timeout[g] = !pwm_valid[g] && (r_cnt[g] == CNT_FIRE);
  end

  // Pending set/clear: a new strobe always wins over the scan clearing the bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_pending_nxt = r_pending | pwm_valid;
    w_capture     = r_pending[r_ptr] | pwm_valid[r_ptr];
    if (r_pending[r_ptr] && !pwm_valid[r_ptr]) w_pending_nxt[r_ptr] = 1'b0;
  end

  // Round-robin scan pointer, pending flags and stage-1 capture.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr     <= '0;
      r_pending <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_ch   <= '0;
      r_s1_t    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_ptr     <= (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
      r_pending <= w_pending_nxt;
      r_s1_vld  <= w_capture;
      r_s1_ch   <= r_ptr;
      r_s1_t    <= w_time[r_ptr];
    end
  end

  // Stage 1: clamp to the calibrated window and remove the MIN_US offset.
  always_comb begin
    w_s1_sat = 1'b0;
    w_s1_d   = '0;
    if (r_s1_t >= MAX_T)     w_s1_sat = 1'b1;
    else if (r_s1_t > MIN_T) w_s1_d   = r_s1_t - MIN_T;
  end

  // Stage 2: scale; the product width leaves headroom so it cannot overflow.
  assign w_s2_p = PROD_W'(r_s2_d) * SCALE;

  // Stage 3: drop the fractional bits, or force full scale when saturated high.
  assign w_s3_v = r_s3_sat ? '1 : VALUE_WIDTH'(r_s3_p >> 16);

  // Stage 2 and stage 3 pipeline registers.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      r_s2_vld <= 1'b0;
      r_s2_ch  <= '0;
      r_s2_d   <= '0;
      r_s2_sat <= 1'b0;
      r_s3_vld <= 1'b0;
      r_s3_ch  <= '0;
      r_s3_p   <= '0;
      r_s3_sat <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      r_s2_ch  <= r_s1_ch;
      r_s2_d   <= w_s1_d;
      r_s2_sat <= w_s1_sat;
      r_s3_vld <= r_s2_vld;
      r_s3_ch  <= r_s2_ch;
      r_s3_p   <= w_s2_p;
      r_s3_sat <= r_s2_sat;
    end
  end

  // Per-channel loss-of-signal counters, saturating at TIMEOUT_US.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: these are a handful of flops, not a RAM, so resetting the whole array is cheap and safe.
      for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= CNT_MAX;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pwm_valid[c])             r_cnt[c] <= '0;
        else if (r_cnt[c] != CNT_MAX) r_cnt[c] <= r_cnt[c] + CNT_W'(1);
      end
    end
  end

  // Output registers: failsafe on timeout, fresh value on a stage-3 write.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CH; c++) r_value[c] <= FAILSAFE;
      stale         <= '1;
      value_updated <= '0;
    end else begin
      value_updated <= w_timeout;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_timeout[c]) begin
          r_value[c] <= FAILSAFE;
          stale[c]   <= 1'b1;
        end
      end
      if (r_s3_vld) begin
        r_value[r_s3_ch]       <= w_s3_v;
        stale[r_s3_ch]         <= 1'b0;
        value_updated[r_s3_ch] <= 1'b1;
      end
    end
  end

endmodule
